// File: rtl/memory_unit_mc_pkg.sv
// memory_unit_mc_pkg: shared op codes, FSM state encoding, default widths
// and small helpers for the multi-channel memory unit.
package memory_unit_mc_pkg;

   // Per-channel operation codes
   typedef enum logic [1:0] {
      GET_CONTENTS = 2'b00,
      SET_CONTENTS = 2'b01,
      GET_FREE     = 2'b10,
      FUNC_RSVD    = 2'b11
   } func_t;

   // Shared execution FSM states (also exported on the debug port)
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ      = 3'd1,
      READ_WAIT = 3'd2,
      WRITE     = 3'd3,
      ALLOC     = 3'd4,
      ZERO      = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam int unsigned DEF_ADDR_W   = 10;
   localparam int unsigned DEF_DATA_W   = 68;
   localparam int unsigned DEF_CHANNELS = 2;

   // Width of a channel index; a single channel still gets one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First execution state for a freshly granted request
   function automatic state_t launch_state(input func_t f);
      case (f)
         GET_CONTENTS: return READ;
         SET_CONTENTS: return WRITE;
         GET_FREE:     return ALLOC;
         default:      return DONE;
      endcase
   endfunction

endpackage

// File: rtl/memory_unit_mc_ram.sv
// mem_ram: synchronous single-port word RAM, one-cycle registered read,
// no reset. The storage array is named ram so it can be preloaded.
module mem_ram
   import memory_unit_mc_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] ram [2**ADDR_W];

   // Single port: a write or a registered read per enabled cycle
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            ram[addr] <= wdata;
         end else begin
            rdata <= ram[addr];
         end
      end
   end

endmodule

// File: rtl/memory_unit_mc.sv
// memory_unit_mc: round-robin arbitration of CHANNELS requesters onto one
// single-port word RAM, serving GET_CONTENTS, SET_CONTENTS and a GET_FREE
// bump allocator with overflow detection.
// Optional build macro MEMORY_UNIT_ZERO_ON_ALLOC_EN: zero each word of a
// successful allocation (one word per cycle) before completing.
module memory_unit_mc
   import memory_unit_mc_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned CHANNELS  = DEF_CHANNELS,
   parameter int unsigned FREE_BASE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2*CHANNELS-1:0]      func,
   input  logic [CHANNELS-1:0]        execute,
   input  logic [ADDR_W*CHANNELS-1:0] address,
   input  logic [DATA_W*CHANNELS-1:0] write_data,
   output logic [DATA_W*CHANNELS-1:0] read_data,
   output logic [ADDR_W*CHANNELS-1:0] free_addr,
   output logic [CHANNELS-1:0]        is_ready,
   output logic [CHANNELS-1:0]        error,
   output logic [2:0]                 state
);

   localparam int unsigned       CH_W      = idx_width(CHANNELS);
   localparam logic [ADDR_W+1:0] MEM_WORDS = {2'b01, {ADDR_W{1'b0}}};

   state_t              state_r, state_nx;
   logic [CH_W-1:0]     cur, last_grant, arb_idx, hi_idx, lo_idx;
   logic                hi_found, lo_found, grant_now;
   logic [CHANNELS-1:0] pending, req;

   func_t               slot_func [CHANNELS];
   logic [ADDR_W-1:0]   slot_addr [CHANNELS];
   logic [DATA_W-1:0]   slot_data [CHANNELS];
   logic [DATA_W-1:0]   rd_r      [CHANNELS];
   logic [ADDR_W-1:0]   fa_r      [CHANNELS];
   logic [CHANNELS-1:0] ready_r, error_r;

   logic                op_err;
   logic [ADDR_W-1:0]   free_ptr;
   logic                full;
   logic [ADDR_W:0]     alloc_cnt;
   logic [ADDR_W+1:0]   alloc_sum;
   logic                alloc_ok;

   logic                ram_en, ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata, ram_rdata;

`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
   localparam logic [ADDR_W:0] ZCNT_LAST = {{ADDR_W{1'b0}}, 1'b1};
   logic [ADDR_W-1:0]   zero_addr;
   logic [ADDR_W:0]     zero_cnt;
`endif

   mem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Round-robin pick: lowest requester above last_grant, else lowest overall.
   // In DONE the finishing channel is masked so its stale slot is not regranted.
   always_comb begin
      req = pending;
      if (state_r == DONE) begin
         req[cur] = 1'b0;
      end
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (req[i] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = CH_W'(i);
         end
         if (req[i] && !hi_found && (CH_W'(i) > last_grant)) begin
            hi_found = 1'b1;
            hi_idx   = CH_W'(i);
         end
      end
      arb_idx = hi_found ? hi_idx : lo_idx;
   end

   // Allocator arithmetic; one spare bit keeps oversize counts from wrapping
   always_comb begin
      alloc_cnt = slot_data[cur][ADDR_W:0];
      alloc_sum = {2'b00, free_ptr} + {1'b0, alloc_cnt};
      alloc_ok  = (alloc_cnt != '0) && !full && (alloc_sum <= MEM_WORDS);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next state, grant strobe and RAM controls.
   // DONE launches the next pending op directly so a queued channel does not
   // pay an extra IDLE cycle; the arbitration rule is unchanged.
   always_comb begin
      state_nx  = state_r;
      grant_now = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = slot_addr[cur];
      ram_wdata = slot_data[cur];
      case (state_r)
         IDLE: begin
            if (lo_found) begin
               grant_now = 1'b1;
               state_nx  = launch_state(slot_func[arb_idx]);
            end
         end
         READ: begin
            ram_en   = 1'b1;
            state_nx = READ_WAIT;
         end
         READ_WAIT: state_nx = DONE;
         WRITE: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            state_nx = DONE;
         end
         ALLOC: begin
`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
            state_nx = alloc_ok ? ZERO : DONE;
`else
            state_nx = DONE;
`endif
         end
`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
         ZERO: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = zero_addr;
            ram_wdata = '0;
            if (zero_cnt == ZCNT_LAST) begin
               state_nx = DONE;
            end
         end
`endif
         DONE: begin
            if (lo_found) begin
               grant_now = 1'b1;
               state_nx  = launch_state(slot_func[arb_idx]);
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: grant bookkeeping, allocator, result registers, request slots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur        <= '0;
         last_grant <= CH_W'(CHANNELS - 1);
         op_err     <= 1'b0;
         free_ptr   <= ADDR_W'(FREE_BASE);
         full       <= 1'b0;
         pending    <= '0;
         ready_r    <= '1;
         error_r    <= '0;
`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
         zero_addr  <= '0;
         zero_cnt   <= '0;
`endif
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            rd_r[i]      <= '0;
            fa_r[i]      <= '0;
            slot_func[i] <= GET_CONTENTS;
            slot_addr[i] <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         if (grant_now) begin
            cur        <= arb_idx;
            last_grant <= arb_idx;
            op_err     <= (slot_func[arb_idx] == FUNC_RSVD);
         end
         if (state_r == ALLOC) begin
            if (alloc_ok) begin
               fa_r[cur] <= free_ptr;
               free_ptr  <= alloc_sum[ADDR_W-1:0];
               if (alloc_sum == MEM_WORDS) begin
                  full <= 1'b1;
               end
`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
               zero_addr <= free_ptr;
               zero_cnt  <= alloc_cnt;
`endif
            end else begin
               op_err <= 1'b1;
            end
         end
`ifdef MEMORY_UNIT_ZERO_ON_ALLOC_EN
         if (state_r == ZERO) begin
            zero_addr <= zero_addr + 1'b1;
            zero_cnt  <= zero_cnt - 1'b1;
         end
`endif
         if (state_r == READ_WAIT) begin
            rd_r[cur] <= ram_rdata;
         end
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if ((state_r == DONE) && (cur == CH_W'(i))) begin
               pending[i] <= 1'b0;
               ready_r[i] <= 1'b1;
               error_r[i] <= op_err;
            end
            if (execute[i] && ready_r[i]) begin
               pending[i]   <= 1'b1;
               ready_r[i]   <= 1'b0;
               error_r[i]   <= 1'b0;
               slot_func[i] <= func_t'(func[2*i +: 2]);
               slot_addr[i] <= address[ADDR_W*i +: ADDR_W];
               slot_data[i] <= write_data[DATA_W*i +: DATA_W];
            end
         end
      end
   end

   // Flatten per-channel result registers onto the packed output buses
   always_comb begin
      read_data = '0;
      free_addr = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         read_data[DATA_W*i +: DATA_W] = rd_r[i];
         free_addr[ADDR_W*i +: ADDR_W] = fa_r[i];
      end
   end

   assign is_ready = ready_r;
   assign error    = error_r;
   assign state    = state_r;

endmodule
